// File: rtl/regfile_mp_sb.sv
`default_nettype none
//==========================================================================
// Module : regfile_mp_sb
// Desc   : Multi-port register file with write-to-read bypass and busy scoreboard.
// Rev    : 1.0
//==========================================================================
module regfile_mp_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 4,
   parameter int NWR    = 2,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [NRD*ADDR_W-1:0]   raddr,
   output logic [NRD*DATA_W-1:0]   rdata,
   output logic [NRD-1:0]          rbusy,
   input  logic [NWR-1:0]          we,
   input  logic [NWR*ADDR_W-1:0]   waddr,
   input  logic [NWR*DATA_W-1:0]   wdata,
   input  logic                    alloc_en,
   input  logic [ADDR_W-1:0]       alloc_addr,
   output logic [(2**ADDR_W)-1:0]  busy_vec
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] r_rf [NREG];
   logic [NREG-1:0]   r_busy;
   logic [NREG-1:0]   w_busy_nxt;

   // Clears first, then the allocate, so allocate wins a same-register collision.
   always_comb begin
      w_busy_nxt = r_busy;
      for (int j = 0; j < NWR; j++) begin
         if (we[j]) w_busy_nxt[waddr[j*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (alloc_en) w_busy_nxt[alloc_addr] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   // Ascending port loop: the last (highest-index) enabled write to an address wins.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int n = 0; n < NREG; n++) r_rf[n] <= '0;
         r_busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*ADDR_W +: ADDR_W] != '0))
               r_rf[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
         end
         r_busy <= w_busy_nxt;
      end
   end

   assign busy_vec = r_busy;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit;
      logic              w_alloc;
      logic [DATA_W-1:0] w_fwd;
      logic [DATA_W-1:0] w_rd;
      logic              w_rb;

      assign w_ra    = raddr[i*ADDR_W +: ADDR_W];
      assign w_alloc = alloc_en && (alloc_addr == w_ra);

      always_comb begin
         w_hit = 1'b0;
         w_fwd = '0;
         for (int j = 0; j < NWR; j++) begin
            if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == w_ra)) begin
               w_hit = 1'b1;
               w_fwd = wdata[j*DATA_W +: DATA_W];
            end
         end
      end

      // A forwarded write hides the busy bit unless the register is being re-allocated.
      always_comb begin
         w_rd = r_rf[w_ra];
         w_rb = r_busy[w_ra];
         if (w_ra == '0) begin
            w_rd = '0;
            w_rb = 1'b0;
         end else if ((BYPASS != 0) && w_hit) begin
            w_rd = w_fwd;
            if (!w_alloc) w_rb = 1'b0;
         end
      end

      assign rdata[i*DATA_W +: DATA_W] = w_rd;
      assign rbusy[i]                  = w_rb;
   end

endmodule
`default_nettype wire
